// File: rtl/chunked_add_sub_unit.sv
// ---------------------------------------------------------------------------
// chunked_add_sub_unit
//
// Multi-cycle two's-complement adder/subtractor for the calculator datapath.
// A + B (sub_i=0) or A - B (sub_i=1) is computed CHUNK bits per clock, with
// the carry registered between chunks, so wide operands never form one long
// ripple chain.
//
// Ports
//   clk_i        clock, everything on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   operands a_i/b_i/sub_i are valid
//   in_ready_o   unit is idle and accepts operands this cycle
//   a_i, b_i     WIDTH-bit operands
//   sub_i        0 = add, 1 = subtract
//   out_valid_o  s_o and the flags hold a finished result
//   out_ready_i  consumer takes the result
//   s_o          WIDTH-bit result (modulo 2^WIDTH)
//   cout_o       carry out of the MSB (for subtract: 1 = no borrow)
//   ovr_o        signed overflow
//   zero_o       result is all zeros
//   neg_o        result MSB
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module chunked_add_sub_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovr_o,
  output logic             zero_o,
  output logic             neg_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  // A width that is not a whole number of chunks has no meaningful
  // schedule, so it is rejected while the design is being elaborated.
  if (WIDTH % CHUNK != 0) begin : gBadChunk
    $error("chunked_add_sub_unit: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    chunkCnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] accA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovr_q;
  logic             zero_q;
  logic             neg_q;
  logic             outValid_q;

  logic [CHUNK:0]   sumChunk;
  logic             carryIntoMsb;
  logic [WIDTH-1:0] accA_d;
  logic [WIDTH-1:0] opB_d;

  // The chunk being worked on always sits in the low CHUNK bits of the
  // operand registers: both operands shift right one chunk per RUN cycle.
  // The vacated top bits of the A register collect the result chunks, so
  // after N shifts that register holds the complete sum with the first
  // chunk back at the bottom. The carry into the MSB is recovered from the
  // sum bit and the two operand bits at that position; it only matters on
  // the last chunk, where that bit is the result MSB.
  always_comb begin
    sumChunk     = {1'b0, accA_q[CHUNK-1:0]} + {1'b0, opB_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_q};
    carryIntoMsb = sumChunk[CHUNK-1] ^ accA_q[CHUNK-1] ^ opB_q[CHUNK-1];
  end

  if (N == 1) begin : gSingle
    assign accA_d = sumChunk[CHUNK-1:0];
    assign opB_d  = opB_q;
  end else begin : gMulti
    assign accA_d = {sumChunk[CHUNK-1:0], accA_q[WIDTH-1:CHUNK]};
    assign opB_d  = {{CHUNK{1'b0}}, opB_q[WIDTH-1:CHUNK]};
  end

  // Control and datapath registers. On accept, B is stored already
  // inverted for subtraction and the initial carry is the +1 of the two's
  // complement, so RUN only ever adds. The result and its flags are loaded
  // once, on the last chunk, and then held untouched until the next result
  // or reset, which keeps them stable under any amount of backpressure.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      chunkCnt_q <= '0;
      carry_q    <= 1'b0;
      accA_q     <= '0;
      opB_q      <= '0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      ovr_q      <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            accA_q     <= a_i;
            opB_q      <= b_i ^ {WIDTH{sub_i}};
            carry_q    <= sub_i;
            chunkCnt_q <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          accA_q     <= accA_d;
          opB_q      <= opB_d;
          carry_q    <= sumChunk[CHUNK];
          chunkCnt_q <= chunkCnt_q + CW'(1);
          if (chunkCnt_q == LAST_CNT) begin
            s_q        <= accA_d;
            cout_q     <= sumChunk[CHUNK];
            ovr_q      <= carryIntoMsb ^ sumChunk[CHUNK];
            zero_q     <= (accA_d == '0);
            neg_q      <= accA_d[WIDTH-1];
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = outValid_q;
  assign s_o         = s_q;
  assign cout_o      = cout_q;
  assign ovr_o       = ovr_q;
  assign zero_o      = zero_q;
  assign neg_o       = neg_q;

endmodule

// File: tb/tb_chunked_add_sub_unit.sv
// ---------------------------------------------------------------------------
// tb_chunked_add_sub_unit
//
// Two units side by side: dut0 with WIDTH=16/CHUNK=4 (four RUN cycles) and
// dut1 with WIDTH=16/CHUNK=16 (one RUN cycle). A timestamp model of each
// unit predicts every output on every cycle from plain integer arithmetic;
// directed vectors add literal expectations for the documented cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_chunked_add_sub_unit;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rstN;

  logic [1:0]         inValid;
  logic [1:0]         inReady;
  logic [1:0][W-1:0]  aIn;
  logic [1:0][W-1:0]  bIn;
  logic [1:0]         subIn;
  logic [1:0]         outValid;
  logic [1:0]         outReady;
  logic [1:0][W-1:0]  sOut;
  logic [1:0]         coutOut;
  logic [1:0]         ovrOut;
  logic [1:0]         zeroOut;
  logic [1:0]         negOut;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit checkEn     = 1'b0;

  bit          mBusy[2];
  int          mAcceptCyc[2];
  int          mResultAt[2];
  logic [19:0] mPend[2];
  logic [19:0] mHeld[2];

  always #5 clk = ~clk;

  // Edge counter used as the model's time base.
  always @(posedge clk) cyc++;

  chunked_add_sub_unit #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .in_valid_i  (inValid[0]),
    .in_ready_o  (inReady[0]),
    .a_i         (aIn[0]),
    .b_i         (bIn[0]),
    .sub_i       (subIn[0]),
    .out_valid_o (outValid[0]),
    .out_ready_i (outReady[0]),
    .s_o         (sOut[0]),
    .cout_o      (coutOut[0]),
    .ovr_o       (ovrOut[0]),
    .zero_o      (zeroOut[0]),
    .neg_o       (negOut[0])
  );

  chunked_add_sub_unit #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .in_valid_i  (inValid[1]),
    .in_ready_o  (inReady[1]),
    .a_i         (aIn[1]),
    .b_i         (bIn[1]),
    .sub_i       (subIn[1]),
    .out_valid_o (outValid[1]),
    .out_ready_i (outReady[1]),
    .s_o         (sOut[1]),
    .cout_o      (coutOut[1]),
    .ovr_o       (ovrOut[1]),
    .zero_o      (zeroOut[1]),
    .neg_o       (negOut[1])
  );

  // Number of RUN cycles of each unit.
  function automatic int nOf(input int d);
    return (d == 0) ? 16 / 4 : 16 / 16;
  endfunction

  // Reference arithmetic on plain integers; returns {s, cout, ovr, zero, neg}.
  function automatic logic [19:0] refOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic sv);
    int sa, sb, ua, ub, exact;
    logic [W-1:0] r;
    logic c, o;
    sa    = int'($signed(av));
    sb    = int'($signed(bv));
    ua    = int'(av);
    ub    = int'(bv);
    exact = sv ? sa - sb : sa + sb;
    r     = exact[W-1:0];
    o     = (exact > 32767) || (exact < -32768);
    c     = sv ? (ua >= ub) : (ua + ub > 65535);
    return {r, c, o, (r == 16'h0000), r[W-1]};
  endfunction

  // One comparison: counts it, reports it when it differs.
  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks one unit against its model, then advances the model by the
  // edge that follows, using the inputs as they stand now.
  task automatic monitorDut(input int d);
    logic        expValid;
    logic [19:0] expOut;
    expValid = mBusy[d] && (cyc >= mResultAt[d]);
    expOut   = expValid ? mPend[d] : mHeld[d];
    if (checkEn) begin
      checkOutput($sformatf("dut%0d out_valid", d), {15'd0, outValid[d]}, {15'd0, expValid});
      checkOutput($sformatf("dut%0d in_ready", d), {15'd0, inReady[d]}, {15'd0, !mBusy[d]});
      checkOutput($sformatf("dut%0d s", d), sOut[d], expOut[19:4]);
      checkOutput($sformatf("dut%0d flags", d),
                  {12'd0, coutOut[d], ovrOut[d], zeroOut[d], negOut[d]},
                  {12'd0, expOut[3:0]});
    end
    if (!rstN) begin
      mBusy[d] = 1'b0;
      mHeld[d] = '0;
    end else if (mBusy[d]) begin
      if (expValid && outReady[d]) begin
        mHeld[d] = mPend[d];
        mBusy[d] = 1'b0;
      end
    end else if (inValid[d]) begin
      mBusy[d]      = 1'b1;
      mAcceptCyc[d] = cyc + 1;
      mResultAt[d]  = cyc + 1 + nOf(d);
      mPend[d]      = refOp(aIn[d], bIn[d], subIn[d]);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitorDut(d);
  end

  // Presents one operation, scrambles the operands right after the accept
  // edge, and returns how many edges after the accept out_valid appeared.
  task automatic applyStimulus(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic sv, output int lat);
    int guard;
    guard = 0;
    while (!inReady[d] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    aIn[d]     = av;
    bIn[d]     = bv;
    subIn[d]   = sv;
    inValid[d] = 1'b1;
    @(posedge clk); #1;
    inValid[d] = 1'b0;
    aIn[d]     = W'($urandom);
    bIn[d]     = W'($urandom);
    subIn[d]   = ~sv;
    lat = 0;
    while (!outValid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("dut%0d out_valid within bound", d), {15'd0, outValid[d]}, 16'd1);
  endtask

  task automatic releaseResult(input int d);
    outReady[d] = 1'b1;
    @(posedge clk); #1;
    outReady[d] = 1'b0;
    checkOutput($sformatf("dut%0d out_valid after release", d), {15'd0, outValid[d]}, 16'd0);
    checkOutput($sformatf("dut%0d in_ready after release", d), {15'd0, inReady[d]}, 16'd1);
  endtask

  // Back-to-back random operations; the model checks every result.
  task automatic randomBurst(input int d, input int count);
    int guard;
    outReady[d] = 1'b1;
    for (int i = 0; i < count; i++) begin
      aIn[d]     = W'($urandom);
      bIn[d]     = (i % 10 == 0) ? aIn[d] : W'($urandom);
      subIn[d]   = 1'($urandom_range(0, 1));
      inValid[d] = 1'b1;
      guard = 0;
      do begin
        @(posedge clk); #1;
        guard++;
        if (d == 0) outReady[0] = ($urandom_range(0, 3) != 0);
      end while (mAcceptCyc[d] != cyc && guard < 40);
      checkOutput($sformatf("dut%0d accept within bound", d), {15'd0, guard < 40}, 16'd1);
    end
    inValid[d]  = 1'b0;
    outReady[d] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    outReady[d] = 1'b0;
  endtask

  initial begin
    int lat;
    for (int d = 0; d < 2; d++) begin
      mBusy[d]      = 1'b0;
      mAcceptCyc[d] = -1;
      mResultAt[d]  = 0;
      mPend[d]      = '0;
      mHeld[d]      = '0;
    end
    rstN     = 1'b0;
    inValid  = '0;
    outReady = '0;
    aIn      = '0;
    bIn      = '0;
    subIn    = '0;
    @(posedge clk); #1;
    rstN    = 1'b1;
    checkEn = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset s", sOut[0], 16'h0000);
    checkOutput("reset flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'h0);
    checkOutput("reset out_valid", {15'd0, outValid[0]}, 16'd0);
    checkOutput("reset in_ready", {15'd0, inReady[0]}, 16'd1);

    $display("[TB] add with latency check");
    applyStimulus(0, 16'h1234, 16'h0FCD, 1'b0, lat);
    checkOutput("t1 latency", 16'(lat), 16'd4);
    checkOutput("t1 s", sOut[0], 16'h2201);
    checkOutput("t1 flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'b0000);
    releaseResult(0);

    $display("[TB] subtract cases");
    applyStimulus(0, 16'h8000, 16'h0001, 1'b1, lat);
    checkOutput("t2a s", sOut[0], 16'h7FFF);
    checkOutput("t2a flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'b1100);
    releaseResult(0);
    applyStimulus(0, 16'h0005, 16'h0005, 1'b1, lat);
    checkOutput("t2b s", sOut[0], 16'h0000);
    checkOutput("t2b flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'b1010);
    releaseResult(0);

    $display("[TB] carry chain and overflow");
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, lat);
    checkOutput("t3a s", sOut[0], 16'h0000);
    checkOutput("t3a flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'b1010);
    releaseResult(0);
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0, lat);
    checkOutput("t3b s", sOut[0], 16'h8000);
    checkOutput("t3b flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'b0101);
    releaseResult(0);

    $display("[TB] backpressure");
    applyStimulus(0, 16'h1111, 16'h2222, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      inValid[0] = (i % 2 == 0);
      aIn[0]     = 16'hAAAA;
      @(posedge clk); #1;
      checkOutput("t4 s held", sOut[0], 16'h3333);
      checkOutput("t4 out_valid held", {15'd0, outValid[0]}, 16'd1);
      checkOutput("t4 in_ready low", {15'd0, inReady[0]}, 16'd0);
    end
    inValid[0] = 1'b0;
    releaseResult(0);
    checkOutput("t4 s after release", sOut[0], 16'h3333);

    $display("[TB] reset mid-operation");
    aIn[0]     = 16'h4321;
    bIn[0]     = 16'h1234;
    subIn[0]   = 1'b0;
    inValid[0] = 1'b1;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    checkOutput("t5 out_valid", {15'd0, outValid[0]}, 16'd0);
    checkOutput("t5 in_ready", {15'd0, inReady[0]}, 16'd1);
    checkOutput("t5 s", sOut[0], 16'h0000);
    checkOutput("t5 flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'h0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t5 no late out_valid", {15'd0, outValid[0]}, 16'd0);
    applyStimulus(0, 16'h0001, 16'h0002, 1'b1, lat);
    checkOutput("t5 s", sOut[0], 16'hFFFF);
    checkOutput("t5 flags", {12'd0, coutOut[0], ovrOut[0], zeroOut[0], negOut[0]}, 16'b0001);
    releaseResult(0);

    $display("[TB] single-chunk unit");
    applyStimulus(1, 16'h00FF, 16'h0F01, 1'b0, lat);
    checkOutput("t6 latency", 16'(lat), 16'd1);
    checkOutput("t6 s", sOut[1], 16'h1000);
    checkOutput("t6 flags", {12'd0, coutOut[1], ovrOut[1], zeroOut[1], negOut[1]}, 16'b0000);
    releaseResult(1);

    $display("[TB] random back-to-back");
    randomBurst(1, 1000);
    randomBurst(0, 300);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
